regfile_wb_arbiter: RTL and testbench

Round-robin arbiter and scoreboard for the single write port of the 8×16-bit register file. Up to NREQ writeback sources (ALU lanes, memory load return, etc.) each present a destination register and data through a valid/ready handshake. One winner per cycle is registered into the write stage that drives the register file's LD_REG, DR and bus inputs. A per-register busy scoreboard tracks reserved-but-unwritten destinations so the issue logic can stall on read-after-write hazards.

---
 rtl/regfile_wb_arbiter_if.sv | 43 ++++
 rtl/regfile_wb_arbiter.sv | 121 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the requesters/issue logic and the register-file
// write arbiter: per-requester write handshakes, scoreboard reservation and
// hazard-check signals, and the registered register-file write port.
interface regfile_wb_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int NREG  = 8,
  parameter int RW    = $clog2(NREG)
);
  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0][RW-1:0]    req_dr;
  logic [NREQ-1:0][WIDTH-1:0] req_data;
  logic [NREQ-1:0]            req_ready;

  logic                       rsv_valid;
  logic [RW-1:0]              rsv_dr;
  logic                       rsv_err;

  logic [RW-1:0]              chk_sr1;
  logic [RW-1:0]              chk_sr2;
  logic                       chk_en1;
  logic                       chk_en2;
  logic                       hazard;

  logic [NREG-1:0]            busy;
  logic                       LD_REG;
  logic [RW-1:0]              DR;
  logic [WIDTH-1:0]           wb_data;

  // Requester / issue side
  modport master (
    output req_valid, req_dr, req_data, rsv_valid, rsv_dr,
           chk_sr1, chk_sr2, chk_en1, chk_en2,
    input  req_ready, rsv_err, hazard, busy, LD_REG, DR, wb_data
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_dr, req_data, rsv_valid, rsv_dr,
           chk_sr1, chk_sr2, chk_en1, chk_en2,
    output req_ready, rsv_err, hazard, busy, LD_REG, DR, wb_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the single register-file write port plus a
// per-register busy scoreboard used by issue logic for RAW hazard stalls.
// The grant is combinational (zero-latency); the winning write is registered
// into LD_REG/DR/wb_data and clears its busy bit when it lands.
module regfile_wb_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int NREG  = 8
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  regfile_wb_arbiter_if.slave  bus
);
  localparam int RW = $clog2(NREG);
  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    w_ptrNext;
  logic [NREQ-1:0]  w_grant;
  logic [PW-1:0]    w_winner;
  logic             w_xfer;

  logic             r_ldReg;
  logic [RW-1:0]    r_dr;
  logic [WIDTH-1:0] r_wbData;

  logic [NREG-1:0]  r_busy;
  logic [NREG-1:0]  w_setMask;
  logic [NREG-1:0]  w_clrMask;
  logic [NREG-1:0]  w_busyNext;
  logic             w_rsvConflict;
  logic             r_rsvErr;

  // Requester index (ptr + offset) wrapped into 0..NREQ-1; NREQ need not be
  // a power of two, so a plain bit truncation is not enough.
  function automatic logic [PW-1:0] wrapIdx(input int v);
    return PW'(v % NREQ);
  endfunction

  // Round-robin search starting at r_ptr; first valid requester wins.
  always_comb begin
    w_grant  = '0;
    w_winner = '0;
    w_xfer   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_xfer && bus.req_valid[wrapIdx(int'(r_ptr) + k)]) begin
        w_xfer                            = 1'b1;
        w_winner                          = wrapIdx(int'(r_ptr) + k);
        w_grant[wrapIdx(int'(r_ptr) + k)] = 1'b1;
      end
    end
  end

  // Pointer moves just past the winner; with no transfer it holds.
  always_comb begin
    w_ptrNext = r_ptr;
    if (w_xfer) begin
      if (int'(w_winner) == NREQ - 1) begin
        w_ptrNext = '0;
      end else begin
        w_ptrNext = w_winner + PW'(1);
      end
    end
  end

  // Grant is masked while reset is held so no handshake can complete.
  assign bus.req_ready = Reset_n ? w_grant : '0;

  // Pointer and registered register-file write port.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_ptr    <= '0;
      r_ldReg  <= 1'b0;
      r_dr     <= '0;
      r_wbData <= '0;
    end else begin
      r_ptr   <= w_ptrNext;
      r_ldReg <= w_xfer;
      if (w_xfer) begin
        r_dr     <= bus.req_dr[w_winner];
        r_wbData <= bus.req_data[w_winner];
      end
    end
  end

  // Scoreboard set/clear masks; a set on the same register as the landing
  // write wins, and re-reserving a busy register that is not being cleared
  // is flagged as an error (the busy bit is already 1, so OR-ing is harmless).
  always_comb begin
    w_setMask = '0;
    w_clrMask = '0;
    if (bus.rsv_valid) begin
      w_setMask[bus.rsv_dr] = 1'b1;
    end
    if (r_ldReg) begin
      w_clrMask[r_dr] = 1'b1;
    end
    w_busyNext    = (r_busy & ~w_clrMask) | w_setMask;
    w_rsvConflict = bus.rsv_valid & r_busy[bus.rsv_dr]
                    & ~(r_ldReg & (r_dr == bus.rsv_dr));
  end

  // Busy bits and the one-cycle reservation-error pulse.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_busy   <= '0;
      r_rsvErr <= 1'b0;
    end else begin
      r_busy   <= w_busyNext;
      r_rsvErr <= w_rsvConflict;
    end
  end

  assign bus.hazard  = (bus.chk_en1 & r_busy[bus.chk_sr1])
                     | (bus.chk_en2 & r_busy[bus.chk_sr2]);
  assign bus.busy    = r_busy;
  assign bus.rsv_err = r_rsvErr;
  assign bus.LD_REG  = r_ldReg;
  assign bus.DR      = r_dr;
  assign bus.wb_data = r_wbData;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter: reset, round-robin order,
// pointer wrap/hold, scoreboard set/clear/hazard, collisions, withdrawal
// and asynchronous reset in the middle of traffic.
module tb_regfile_wb_arbiter;
  logic Clk;
  logic Reset_n;
  int   nCompared;
  int   nMismatch;

  regfile_wb_arbiter_if #(.NREQ(4), .WIDTH(16), .NREG(8)) bus ();

  regfile_wb_arbiter #(.NREQ(4), .WIDTH(16), .NREG(8)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatch++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Restore default requester payloads: req_dr[i]=i, req_data[i]=A000+i.
  task automatic applyStimulus();
    for (int i = 0; i < 4; i++) begin
      bus.req_dr[i]   = 3'(i);
      bus.req_data[i] = 16'hA000 + 16'(i);
    end
  endtask

  // Linear directed sequence.
  initial begin
    nCompared     = 0;
    nMismatch     = 0;
    Reset_n       = 1'b0;
    bus.req_valid = '0;
    bus.rsv_valid = 1'b0;
    bus.rsv_dr    = '0;
    bus.chk_sr1   = '0;
    bus.chk_sr2   = '0;
    bus.chk_en1   = 1'b0;
    bus.chk_en2   = 1'b0;
    applyStimulus();

    #2;
    checkOutput("rst_ready",  32'(bus.req_ready), 32'h0);
    checkOutput("rst_ld",     32'(bus.LD_REG),    32'h0);
    checkOutput("rst_dr",     32'(bus.DR),        32'h0);
    checkOutput("rst_data",   32'(bus.wb_data),   32'h0);
    checkOutput("rst_busy",   32'(bus.busy),      32'h0);
    checkOutput("rst_rsverr", 32'(bus.rsv_err),   32'h0);
    checkOutput("rst_hazard", 32'(bus.hazard),    32'h0);
    tick();
    #2 Reset_n = 1'b1;
    tick();

    // Round robin: all four valid for 8 cycles -> grants 0,1,2,3,0,1,2,3.
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1;
      checkOutput("rr_ready", 32'(bus.req_ready), 32'(1 << (c % 4)));
      if (c > 0) begin
        checkOutput("rr_ld",   32'(bus.LD_REG),  32'h1);
        checkOutput("rr_dr",   32'(bus.DR),      32'((c - 1) % 4));
        checkOutput("rr_data", 32'(bus.wb_data), 32'h0000A000 + 32'((c - 1) % 4));
      end
      tick();
    end
    checkOutput("rr_last_dr", 32'(bus.DR),   32'h3);
    checkOutput("rr_busy",    32'(bus.busy), 32'h0);

    // Pointer skip: grant 1 alone, then 0011 wraps to 0, then 1.
    bus.req_valid = 4'b0010;
    #1 checkOutput("skip_g1", 32'(bus.req_ready), 32'b0010);
    tick();
    bus.req_valid = 4'b0011;
    #1 checkOutput("skip_wrap0", 32'(bus.req_ready), 32'b0001);
    tick();
    checkOutput("skip_dr0", 32'(bus.DR), 32'h0);
    #1 checkOutput("skip_then1", 32'(bus.req_ready), 32'b0010);
    tick();
    bus.req_valid = 4'b0000;
    #1 checkOutput("idle_ready", 32'(bus.req_ready), 32'h0);
    tick();
    checkOutput("idle_ld",   32'(bus.LD_REG),  32'h0);
    checkOutput("idle_dr",   32'(bus.DR),      32'h1);
    checkOutput("idle_data", 32'(bus.wb_data), 32'h0000A001);
    bus.req_valid = 4'b1111;
    #1 checkOutput("idle_ptr_hold", 32'(bus.req_ready), 32'b0100);
    bus.req_valid = 4'b0000;

    // Scoreboard: reserve R5, write it through requester 2, watch busy/hazard.
    bus.rsv_valid = 1'b1;
    bus.rsv_dr    = 3'd5;
    tick();
    bus.rsv_valid = 1'b0;
    checkOutput("sb_busy_set", 32'(bus.busy),    32'h20);
    checkOutput("sb_no_err",   32'(bus.rsv_err), 32'h0);
    bus.chk_sr1 = 3'd5;
    bus.chk_en1 = 1'b1;
    #1 checkOutput("sb_hazard", 32'(bus.hazard), 32'h1);
    bus.chk_en1 = 1'b0;
    #1 checkOutput("sb_hazard_dis", 32'(bus.hazard), 32'h0);
    bus.chk_en1 = 1'b1;
    bus.req_dr[2]   = 3'd5;
    bus.req_data[2] = 16'h1234;
    bus.req_valid   = 4'b0100;
    #1 checkOutput("sb_ready2", 32'(bus.req_ready), 32'b0100);
    tick();
    bus.req_valid = 4'b0000;
    checkOutput("sb_wr_ld",     32'(bus.LD_REG),  32'h1);
    checkOutput("sb_wr_dr",     32'(bus.DR),      32'h5);
    checkOutput("sb_wr_data",   32'(bus.wb_data), 32'h1234);
    checkOutput("sb_busy_hold", 32'(bus.busy),    32'h20);
    checkOutput("sb_haz_hold",  32'(bus.hazard),  32'h1);
    tick();
    checkOutput("sb_busy_clr", 32'(bus.busy),   32'h0);
    checkOutput("sb_haz_clr",  32'(bus.hazard), 32'h0);
    checkOutput("sb_ld_off",   32'(bus.LD_REG), 32'h0);
    bus.chk_en1 = 1'b0;

    // Collision: re-reserving busy R3 pulses rsv_err for one cycle.
    bus.rsv_valid = 1'b1;
    bus.rsv_dr    = 3'd3;
    tick();
    checkOutput("col_busy3",  32'(bus.busy),    32'h08);
    checkOutput("col_noerr",  32'(bus.rsv_err), 32'h0);
    tick();
    bus.rsv_valid = 1'b0;
    checkOutput("col_err",       32'(bus.rsv_err), 32'h1);
    checkOutput("col_busy_keep", 32'(bus.busy),    32'h08);
    bus.chk_sr2 = 3'd3;
    bus.chk_en2 = 1'b1;
    #1 checkOutput("col_hazard2", 32'(bus.hazard), 32'h1);
    bus.chk_en2 = 1'b0;
    tick();
    checkOutput("col_err_pulse", 32'(bus.rsv_err), 32'h0);

    // Same-edge set and clear of R3: set wins, no error.
    bus.req_dr[0] = 3'd3;
    bus.req_valid = 4'b0001;
    #1 checkOutput("same_ready0", 32'(bus.req_ready), 32'b0001);
    tick();
    bus.req_valid = 4'b0000;
    checkOutput("same_ld_dr3", 32'(bus.DR), 32'h3);
    bus.rsv_valid = 1'b1;
    bus.rsv_dr    = 3'd3;
    tick();
    bus.rsv_valid = 1'b0;
    checkOutput("same_busy", 32'(bus.busy),    32'h08);
    checkOutput("same_err",  32'(bus.rsv_err), 32'h0);
    bus.req_valid = 4'b0001;
    tick();
    bus.req_valid = 4'b0000;
    tick();
    checkOutput("same_final_clr", 32'(bus.busy), 32'h0);
    applyStimulus();

    // Withdrawal: requester 3 (targeting R7) drops valid before its turn.
    bus.req_dr[3]   = 3'd7;
    bus.req_data[3] = 16'hBEEF;
    bus.req_valid   = 4'b1110;
    #1 checkOutput("wd_g1", 32'(bus.req_ready), 32'b0010);
    tick();
    bus.req_valid = 4'b0110;
    #1 checkOutput("wd_g2", 32'(bus.req_ready), 32'b0100);
    checkOutput("wd_dr1", 32'(bus.DR), 32'h1);
    tick();
    bus.req_valid = 4'b0010;
    #1 checkOutput("wd_skip3", 32'(bus.req_ready), 32'b0010);
    checkOutput("wd_dr2", 32'(bus.DR), 32'h2);
    tick();
    bus.req_valid = 4'b0000;
    checkOutput("wd_dr1b", 32'(bus.DR), 32'h1);
    tick();
    checkOutput("wd_no7", 32'(bus.DR), 32'h1);
    applyStimulus();

    // Asynchronous reset in the middle of traffic with a busy register.
    bus.rsv_valid = 1'b1;
    bus.rsv_dr    = 3'd6;
    bus.req_valid = 4'b1111;
    tick();
    bus.rsv_valid = 1'b0;
    checkOutput("mid_busy6", 32'(bus.busy),   32'h40);
    checkOutput("mid_ld",    32'(bus.LD_REG), 32'h1);
    Reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_ready", 32'(bus.req_ready), 32'h0);
    checkOutput("mid_rst_ld",    32'(bus.LD_REG),    32'h0);
    checkOutput("mid_rst_busy",  32'(bus.busy),      32'h0);
    checkOutput("mid_rst_dr",    32'(bus.DR),        32'h0);
    tick();
    checkOutput("mid_rst_held", 32'(bus.LD_REG), 32'h0);
    #3 Reset_n = 1'b1;
    #1 checkOutput("post_rst_g0", 32'(bus.req_ready), 32'b0001);
    tick();
    bus.req_valid = 4'b0000;
    checkOutput("post_rst_ld",   32'(bus.LD_REG),  32'h1);
    checkOutput("post_rst_dr",   32'(bus.DR),      32'h0);
    checkOutput("post_rst_data", 32'(bus.wb_data), 32'h0000A000);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end
endmodule
